// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Sequencing controller for the stopwatch datapath. Keeps the MM:SS count in
// BCD, runs the RUN / PAUSE / ADJ state machine and produces per-field blanking
// for the 7-segment display driver.
//
// Parameters
//   MIN_MAX      highest minute value (1..99); minutes wrap to 00 after it
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous, active-high hard reset
//   tick_1hz     one-cycle pulse, advances the count in RUN
//   tick_2hz     one-cycle pulse, advances the selected field in ADJ
//   tick_blink   one-cycle pulse, toggles the blink phase in ADJ
//   pause_p      one-cycle pulse from the debounced pause button
//   clear_p      one-cycle pulse from the debounced reset button (soft clear)
//   adj          level, 1 requests adjust mode
//   sel          level, field to adjust: 0 = minutes, 1 = seconds
//   min_tens, min_ones, sec_tens, sec_ones
//                registered BCD digits
//   blank_min, blank_sec
//                registered, 1 = display driver blanks that field
//   running      registered, 1 while the state is RUN
//   state_dbg    current state encoding (0 = RUN, 1 = PAUSE, 2 = ADJ)
//
// Handshake note: there is no valid/ready traffic here. Every tick and button
// input is a single-cycle strobe that is consumed on the edge that samples it;
// a strobe held high for N cycles is N events. adj and sel are plain levels.
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int MIN_MAX = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_blink,
    input  logic       pause_p,
    input  logic       clear_p,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       blank_min,
    output logic       blank_sec,
    output logic       running,
    output logic [1:0] state_dbg
);

    // Minute wrap point split into BCD digits at elaboration time.
    localparam logic [3:0] MAX_TENS = 4'(MIN_MAX / 10);
    localparam logic [3:0] MAX_ONES = 4'(MIN_MAX % 10);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_ADJ   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       resume_paused;
    logic       resume_nx;
    logic       blink_phase;
    logic       blink_nx;

    logic       running_nx;
    logic       blank_min_nx;
    logic       blank_sec_nx;

    // Incremented candidates for each field, computed unconditionally.
    logic [3:0] sec_tens_inc;
    logic [3:0] sec_ones_inc;
    logic       sec_wrap;
    logic [3:0] min_tens_inc;
    logic [3:0] min_ones_inc;

    logic [3:0] min_tens_nx;
    logic [3:0] min_ones_nx;
    logic [3:0] sec_tens_nx;
    logic [3:0] sec_ones_nx;

    assign state_dbg = state;

    // -------------------------------------------------------------------------
    // FSM: state register (also holds the registered outputs derived from it)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_RUN;
            resume_paused <= 1'b0;
            blink_phase   <= 1'b0;
            running       <= 1'b1;
            blank_min     <= 1'b0;
            blank_sec     <= 1'b0;
        end else begin
            state         <= state_nx;
            resume_paused <= resume_nx;
            blink_phase   <= blink_nx;
            running       <= running_nx;
            blank_min     <= blank_min_nx;
            blank_sec     <= blank_sec_nx;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic. adj outranks pause_p in every state.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        resume_nx = resume_paused;
        case (state)
            ST_RUN: begin
                if (adj) begin
                    state_nx  = ST_ADJ;
                    resume_nx = 1'b0;
                end else if (pause_p) begin
                    state_nx = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (adj) begin
                    state_nx  = ST_ADJ;
                    resume_nx = 1'b1;
                end else if (pause_p) begin
                    state_nx = ST_RUN;
                end
            end
            ST_ADJ: begin
                if (!adj) begin
                    state_nx = resume_paused ? ST_PAUSE : ST_RUN;
                end else if (pause_p) begin
                    // Pause while adjusting only changes where we return to.
                    resume_nx = ~resume_paused;
                end
            end
            default: begin
                state_nx  = ST_RUN;
                resume_nx = 1'b0;
            end
        endcase

        // Phase only advances while we stay in ADJ; entering or leaving ADJ,
        // and any other state, forces it back to 0.
        if (state == ST_ADJ && state_nx == ST_ADJ) begin
            blink_nx = blink_phase ^ tick_blink;
        end else begin
            blink_nx = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output logic. Computed from next-state values so the registered
    // outputs change on the same edge as the state; sel is sampled here so
    // blanking follows a sel change one cycle later without resetting phase.
    // -------------------------------------------------------------------------
    always_comb begin
        running_nx   = (state_nx == ST_RUN);
        blank_min_nx = (state_nx == ST_ADJ) && !sel && blink_nx;
        blank_sec_nx = (state_nx == ST_ADJ) &&  sel && blink_nx;
    end

    // -------------------------------------------------------------------------
    // BCD incrementers
    // -------------------------------------------------------------------------
    always_comb begin
        sec_tens_inc = sec_tens;
        sec_ones_inc = sec_ones + 4'd1;
        sec_wrap     = 1'b0;
        if (sec_ones >= 4'd9) begin
            sec_ones_inc = 4'd0;
            if (sec_tens >= 4'd5) begin
                sec_tens_inc = 4'd0;
                sec_wrap     = 1'b1;
            end else begin
                sec_tens_inc = sec_tens + 4'd1;
            end
        end
    end

    always_comb begin
        min_tens_inc = min_tens;
        min_ones_inc = min_ones + 4'd1;
        // Wrap compares the whole BCD pair, so MIN_MAX need not end in 9.
        if (min_tens == MAX_TENS && min_ones == MAX_ONES) begin
            min_tens_inc = 4'd0;
            min_ones_inc = 4'd0;
        end else if (min_ones >= 4'd9) begin
            min_ones_inc = 4'd0;
            min_tens_inc = min_tens + 4'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Count update, keyed on the current (pre-edge) state. clear_p wins over
    // any tick in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        min_tens_nx = min_tens;
        min_ones_nx = min_ones;
        sec_tens_nx = sec_tens;
        sec_ones_nx = sec_ones;
        if (clear_p) begin
            min_tens_nx = 4'd0;
            min_ones_nx = 4'd0;
            sec_tens_nx = 4'd0;
            sec_ones_nx = 4'd0;
        end else if (state == ST_RUN && tick_1hz) begin
            sec_tens_nx = sec_tens_inc;
            sec_ones_nx = sec_ones_inc;
            if (sec_wrap) begin
                min_tens_nx = min_tens_inc;
                min_ones_nx = min_ones_inc;
            end
        end else if (state == ST_ADJ && tick_2hz) begin
            // Adjusting one field never carries into the other.
            if (sel) begin
                sec_tens_nx = sec_tens_inc;
                sec_ones_nx = sec_ones_inc;
            end else begin
                min_tens_nx = min_tens_inc;
                min_ones_nx = min_ones_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
        end else begin
            min_tens <= min_tens_nx;
            min_ones <= min_ones_nx;
            sec_tens <= sec_tens_nx;
            sec_ones <= sec_ones_nx;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Bench for stopwatch_ctrl (MIN_MAX = 99). A behavioural model keeps the count
// as plain integer minutes/seconds and the mode as a small state number; a
// compare process checks every DUT output against it on each falling edge.
// Directed sequences pin the model with hand-computed literals, then a
// randomized phase drives all inputs with $urandom.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int MIN_MAX = 99;
    localparam int M_RUN   = 0;
    localparam int M_PAUSE = 1;
    localparam int M_ADJ   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic       tick_blink = 1'b0;
    logic       pause_p = 1'b0;
    logic       clear_p = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       blank_min;
    logic       blank_sec;
    logic       running;
    logic [1:0] state_dbg;

    stopwatch_ctrl #(.MIN_MAX(MIN_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .tick_2hz   (tick_2hz),
        .tick_blink (tick_blink),
        .pause_p    (pause_p),
        .clear_p    (clear_p),
        .adj        (adj),
        .sel        (sel),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .blank_min  (blank_min),
        .blank_sec  (blank_sec),
        .running    (running),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic logic [15:0] to_bcd(input int mins, input int secs);
        logic [15:0] v;
        v = {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    int m_min = 0;
    int m_sec = 0;
    int m_st = M_RUN;
    bit m_res = 1'b0;
    bit m_blink = 1'b0;
    bit m_sel = 1'b0;

    initial begin
        int nst;
        bit nres;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_min = 0; m_sec = 0; m_st = M_RUN;
                m_res = 1'b0; m_blink = 1'b0; m_sel = 1'b0;
            end else begin
                // count, keyed on the mode before this edge
                if (clear_p) begin
                    m_min = 0;
                    m_sec = 0;
                end else if (m_st == M_RUN && tick_1hz) begin
                    m_sec = m_sec + 1;
                    if (m_sec == 60) begin
                        m_sec = 0;
                        m_min = (m_min == MIN_MAX) ? 0 : m_min + 1;
                    end
                end else if (m_st == M_ADJ && tick_2hz) begin
                    if (sel) m_sec = (m_sec + 1) % 60;
                    else     m_min = (m_min == MIN_MAX) ? 0 : m_min + 1;
                end
                // mode
                nst = m_st;
                nres = m_res;
                if (m_st == M_ADJ) begin
                    if (!adj) nst = m_res ? M_PAUSE : M_RUN;
                    else if (pause_p) nres = !m_res;
                end else if (adj) begin
                    nst = M_ADJ;
                    nres = (m_st == M_PAUSE);
                end else if (pause_p) begin
                    nst = (m_st == M_RUN) ? M_PAUSE : M_RUN;
                end
                m_blink = (m_st == M_ADJ && nst == M_ADJ) ? (m_blink ^ tick_blink) : 1'b0;
                m_st = nst;
                m_res = nres;
                m_sel = sel;
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("digits", digits(), to_bcd(m_min, m_sec));
            chk("running", 16'(running), 16'(m_st == M_RUN));
            chk("blank_min", 16'(blank_min), 16'(m_st == M_ADJ && !m_sel && m_blink));
            chk("blank_sec", 16'(blank_sec), 16'(m_st == M_ADJ && m_sel && m_blink));
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+2: apply strobes for one cycle, return at next posedge+2.
    task automatic cyc(input logic t1, input logic t2, input logic tb, input logic pp, input logic cp);
        tick_1hz = t1; tick_2hz = t2; tick_blink = tb; pause_p = pp; clear_p = cp;
        @(posedge clk); #2;
        tick_1hz = 1'b0; tick_2hz = 1'b0; tick_blink = 1'b0; pause_p = 1'b0; clear_p = 1'b0;
    endtask

    task automatic ticks1(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks2(input int n);
        repeat (n) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 rst = 1'b1;
        #1 chk("reset_digits", digits(), 16'h0000);
        chk("reset_running", 16'(running), 16'd1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // reset and count
        ticks1(61);
        chk("count_61", digits(), 16'h0101);
        chk("count_running", 16'(running), 16'd1);
        chk("count_blanks", {14'd0, blank_min, blank_sec}, 16'd0);

        // full wrap: preload 99:58 via ADJ
        adj = 1'b1; sel = 1'b0;
        idle(1);
        ticks2(98);
        sel = 1'b1;
        ticks2(57);
        adj = 1'b0;
        idle(1);
        chk("preload", digits(), 16'h9958);
        chk("preload_running", 16'(running), 16'd1);
        ticks1(1);
        chk("wrap_9959", digits(), 16'h9959);
        ticks1(1);
        chk("wrap_0000", digits(), 16'h0000);

        // pause / resume
        ticks1(10);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pause_running", 16'(running), 16'd0);
        ticks1(5);
        chk("pause_hold", digits(), 16'h0010);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks1(1);
        chk("resume_count", digits(), 16'h0011);
        chk("resume_running", 16'(running), 16'd1);

        // adjust from PAUSE at 00:58
        ticks1(47);
        chk("at_0058", digits(), 16'h0058);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        adj = 1'b1; sel = 1'b1;
        idle(1);
        ticks2(3);
        chk("adj_sec_nocarry", digits(), 16'h0001);
        sel = 1'b0;
        ticks2(2);
        chk("adj_min", digits(), 16'h0201);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("blink_min", 16'(blank_min), 16'((i % 2) == 0));
            chk("blink_sec_off", 16'(blank_sec), 16'd0);
        end
        adj = 1'b0;
        idle(1);
        chk("adj_exit_running", 16'(running), 16'd0);
        chk("adj_exit_blanks", {14'd0, blank_min, blank_sec}, 16'd0);
        chk("adj_exit_digits", digits(), 16'h0201);

        // simultaneous events
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clear", digits(), 16'h0000);
        ticks1(5);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pause_tick_digits", digits(), 16'h0006);
        chk("pause_tick_running", 16'(running), 16'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clear_tick", digits(), 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("pause_clear_running", 16'(running), 16'd1);

        // async reset mid-ADJ at 12:34 with blink phase 1
        adj = 1'b1; sel = 1'b0;
        idle(1);
        ticks2(12);
        sel = 1'b1;
        ticks2(34);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_digits", digits(), 16'h1234);
        chk("pre_rst_blank_sec", 16'(blank_sec), 16'd1);
        #1 rst = 1'b1;
        #1 chk("async_rst_digits", digits(), 16'h0000);
        chk("async_rst_running", 16'(running), 16'd1);
        chk("async_rst_blanks", {14'd0, blank_min, blank_sec}, 16'd0);
        adj = 1'b0; sel = 1'b0;
        rst = 1'b0;
        @(posedge clk); #2;

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) adj = ~adj;
            if ($urandom_range(0, 9) == 0) sel = ~sel;
            tick_1hz   = ($urandom_range(0, 2) == 0);
            tick_2hz   = ($urandom_range(0, 3) == 0);
            tick_blink = ($urandom_range(0, 3) == 0);
            pause_p    = ($urandom_range(0, 15) == 0);
            clear_p    = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            @(posedge clk); #2;
        end
        tick_1hz = 1'b0; tick_2hz = 1'b0; tick_blink = 1'b0;
        pause_p = 1'b0; clear_p = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the stopwatch datapath. It consumes the single-cycle tick pulses from the clock divider (1 Hz count, 2 Hz adjust, 4 Hz blink) and the conditioned button pulses. It maintains the MM:SS count in BCD, runs the RUN/PAUSE/ADJUST state machine, and drives per-field blanking for the 7-segment display driver.

## Interface
- MIN_MAX, default 99: highest minute value; legal range 1..99; minutes wrap to 00 after MIN_MAX.
- clk  in  1  100 MHz system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high hard reset.
- tick_1hz  in  1  one-cycle pulse, 1 Hz; advances count in RUN.
- tick_2hz  in  1  one-cycle pulse, 2 Hz; advances selected field in ADJ.
- tick_blink  in  1  one-cycle pulse, 4 Hz; toggles blink phase in ADJ.
- pause_p  in  1  one-cycle pulse from debounced pause button.
- clear_p  in  1  one-cycle pulse from debounced reset button; soft clear.
- adj  in  1  level; 1 requests adjust mode.
- sel  in  1  level; field to adjust: 0 = minutes, 1 = seconds.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD digits, registered.
- blank_min, blank_sec  out  1 each  1 = display driver blanks that field.
- running  out  1  1 when state is RUN.

## Operation
- States: RUN, PAUSE, ADJ. There is one extra register, resume_paused, which holds the state to return to when leaving ADJ.
- Transitions are evaluated on the current registered state. Priority is highest first: adj, then pause_p.
  - RUN: adj=1 → ADJ with resume_paused=0. Otherwise pause_p → PAUSE.
  - PAUSE: adj=1 → ADJ with resume_paused=1. Otherwise pause_p → RUN.
  - ADJ: adj=0 → PAUSE if resume_paused, else RUN. pause_p while adj=1 toggles resume_paused and the state stays ADJ.
- Count actions are keyed on the current state. clear_p overrides all of them.
  - RUN, tick_1hz: seconds +1. 59 → 00 with minutes +1. Minutes at MIN_MAX → 00, so MIN_MAX:59 → 00:00.
  - PAUSE: count holds and all ticks are ignored.
  - ADJ, tick_2hz: only the field chosen by sel increments.
    - Seconds 59 → 00 with no carry into minutes.
    - Minutes MIN_MAX → 00.
    - The other field holds. tick_1hz is ignored.
  - clear_p in any state: all digits → 0 on the next edge. State and resume_paused are unchanged.
- BCD arithmetic: ones digit 9 → 0 with tens +1.
  - Seconds tens wraps after 5.
  - Minute wrap compares the full BCD pair against MIN_MAX. MIN_MAX is converted to tens/ones at elaboration.
- Digits never hold a non-BCD value.
- Blink:
  - blink_phase toggles on tick_blink only in ADJ.
  - blink_phase is forced to 0 in any other state and on ADJ entry.
  - blank_sec = ADJ & sel & blink_phase.
  - blank_min = ADJ & ~sel & blink_phase.
  - Changing sel moves blanking to the new field the next cycle; the phase is not reset.

## Timing
- Hard reset (rst=1, asynchronous): state=RUN, resume_paused=0, blink_phase=0, all digits 0, blank_min=0, blank_sec=0, running=1.
- Counting resumes on the first tick_1hz after rst deasserts.
- Latency:
  - Digit outputs change on the edge that samples the tick, 1 cycle after the tick is high.
  - running and blank outputs are registered from the state, so they change 1 cycle after the causing input.
- Simultaneous events in the same cycle:
  - RUN with pause_p and tick_1hz: the increment is applied and the state → PAUSE.
  - RUN with adj rising and tick_1hz: the increment is applied and the state → ADJ. A tick_2hz in that cycle is ignored, because the state is still RUN.
  - ADJ with adj falling and tick_2hz: the adjust increment is applied and the state leaves ADJ.
  - clear_p with any tick: digits → 0 and the tick is discarded.
  - pause_p and clear_p together: the state transition occurs and digits → 0.
- Ticks are assumed to be one cycle wide. A tick held high for N cycles gives N increments. There is no edge detection.
- rst mid-operation, including mid-ADJ or mid-carry: everything returns to reset values immediately, with no partial carry retained.

## Test plan
- Reset and count: assert rst, then release it and apply 61 tick_1hz pulses → digits 01:01, running=1, blank_min=0, blank_sec=0.
- Full wrap (MIN_MAX=99): preload 99:58 via ADJ, return to RUN, then apply 2 tick_1hz pulses → 99:59, then 00:00.
- Pause/resume:
  - At 00:10 pulse pause_p → running=0.
  - Apply 5 tick_1hz pulses → still 00:10.
  - Pulse pause_p again, then 1 tick_1hz → 00:11.
- Adjust:
  - From PAUSE at 00:58, set adj=1, sel=1, then 3 tick_2hz pulses → 00:01 with minutes unchanged.
  - Set sel=0, then 2 tick_2hz pulses → 02:01.
  - 4 tick_blink pulses → blank_min toggles 1,0,1,0.
  - Set adj=0 → PAUSE, running=0, blanks=0.
- Simultaneous events:
  - In RUN at 00:05, pause_p and tick_1hz in the same cycle → 00:06 and PAUSE.
  - clear_p and tick_1hz in the same cycle → 00:00.
- Async reset mid-ADJ: in ADJ with blink_phase=1 at 12:34, pulse rst between clock edges → outputs 00:00, blanks 0 and running=1 before the next edge.
